mem_bus_master: RTL

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_bus_master.sv
// Command-driven master for a simple shared-bus memory: single reads/writes,
// fills and read bursts, with a turnaround cycle between every operation.
module mem_bus_master #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [LWIDTH-1:0] req_len,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [LWIDTH-1:0]   cnt_q, cnt_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                beat;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    req_ready = 1'b0;
    beat      = 1'b0;

    if (rvalid_q && resp_ready) rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_cmd[1] ? req_len : '0;
          wdata_d = req_wdata;
          state_d = (req_cmd[0] ^ req_cmd[1]) ? WRITE : READ;
        end
      end
      WRITE: beat = 1'b1;
      READ: begin
        // A held response blocks the next capture, which stalls the burst.
        if (!rvalid_q || resp_ready) begin
          rdata_d  = mem_data;
          rvalid_d = 1'b1;
          beat     = 1'b1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (beat) begin
      addr_d = addr_q + AWIDTH'(1);
      if (cnt_q == '0) state_d = TURN;
      else             cnt_d   = cnt_q - LWIDTH'(1);
    end

    // Strobes come from the next state so they leave the flops glitch-free.
    rd_d = (state_d == READ);
    wr_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign mem_data   = wr_q ? wdata_q : {DWIDTH{1'bz}};

endmodule
